// File: rtl/i2c_slave_frontend_pkg.sv
// Shared definitions for the I2C slave front end.
//   i2c_state_e    : FSM state encoding of the bit-level engine
//   I2C_ACK/NACK   : SDA level of an acknowledge / not-acknowledge bit
//   I2C_RW_READ    : value of the R/W address bit for a read transfer
//   I2C_ADDR_UNSET : slave address value meaning "not latched yet"
//   I2C_LAST_BIT   : bit counter value of the eighth bit of a byte
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic       I2C_ACK        = 1'b0;
  localparam logic       I2C_NACK       = 1'b1;
  localparam logic       I2C_RW_READ    = 1'b1;
  localparam logic [6:0] I2C_ADDR_UNSET = 7'd0;
  localparam logic [2:0] I2C_LAST_BIT   = 3'd7;

endpackage

// File: rtl/i2c_slave_frontend_if.sv
// Bus bundle between the I2C slave front end and its surroundings
// (pads, address-config block, register side).
//   slave  modport : view of the front end itself
//   master modport : view of the pads / register side driving it
interface i2c_slave_frontend_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic [6:0] slave_address_i;
  logic       start_o;
  logic       stop_o;
  logic       addressed_o;
  logic       rw_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       tx_req_o;
  logic [7:0] tx_data_i;
  logic       busy_o;

  modport slave (
    input  scl_i, sda_i, slave_address_i, tx_data_i,
    output sda_oe_o, start_o, stop_o, addressed_o, rw_o,
           rx_data_o, rx_valid_o, tx_req_o, busy_o
  );

  modport master (
    output scl_i, sda_i, slave_address_i, tx_data_i,
    input  sda_oe_o, start_o, stop_o, addressed_o, rw_o,
           rx_data_o, rx_valid_o, tx_req_o, busy_o
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into clk_i and derives single-cycle events.
//   clk_i, rst_n_i : clock, async active-low reset
//   scl_i, sda_i   : raw pad inputs
//   sda_o          : synchronized SDA level
//   scl_rise_o     : synced SCL rising edge pulse
//   scl_fall_o     : synced SCL falling edge pulse
//   start_o        : SDA fell while SCL high
//   stop_o         : SDA rose while SCL high
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_d;
  assign scl_fall_o = ~scl_s & scl_d;
  assign start_o    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_o     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_frontend.sv
// Bit-level I2C slave engine: address match, ACK generation, write byte
// strobes and read byte fetch. No clock stretching; only SDA is driven.
//   clk_i, rst_n_i : clock, async active-low reset
//   bus            : i2c_slave_frontend_if.slave (pads, own address,
//                    rx/tx byte interface, status)
//
// state        | meaning
// ST_IDLE      | bus free, nothing in progress
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | own address seen; drive ACK for one bit
// ST_WR_DATA   | shifting in a write byte
// ST_WR_ACK    | drive ACK for a received byte
// ST_RD_DATA   | shifting out a read byte
// ST_RD_ACK    | sampling master ACK/NACK
// ST_WAIT_STOP | not ours or NACKed; ignore until STOP/START
module i2c_slave_frontend
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  i2c_slave_frontend_if.slave bus
);

  logic sda_s, scl_rise, scl_fall, start_p, stop_p;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .scl_i      (bus.scl_i),
    .sda_i      (bus.sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_p),
    .stop_o     (stop_p)
  );

  i2c_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d, addressed_q, addressed_d, rw_q, rw_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, rx_load_q, rx_load_d;
  logic [7:0] shift_in;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      rx_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      rx_load_q   <= rx_load_d;
    end
  end

  assign shift_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    rx_load_d   = 1'b0;

    // A completed write byte is published the cycle after its last bit.
    if (rx_load_q) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end

    if (start_p) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_p) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = shift_in;
          if (bit_cnt_q == I2C_LAST_BIT) begin
            bit_cnt_d = 3'd0;
            if (shift_in[7:1] == bus.slave_address_i &&
                bus.slave_address_i != I2C_ADDR_UNSET) begin
              state_d = ST_ADDR_ACK;
              rw_d    = shift_in[0];
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        // sda_oe_q doubles as the phase flag: low = ACK bit not started yet.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d    = ~I2C_ACK;
            addressed_d = 1'b1;
            tx_req_d    = (rw_q == I2C_RW_READ);
          end else if (rw_q == I2C_RW_READ) begin
            state_d   = ST_RD_DATA;
            shift_d   = bus.tx_data_i;
            sda_oe_d  = ~bus.tx_data_i[7];
            bit_cnt_d = 3'd0;
          end else begin
            state_d   = ST_WR_DATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d = shift_in;
          if (bit_cnt_q == I2C_LAST_BIT) begin
            rx_load_d = 1'b1;
            state_d   = ST_WR_ACK;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~I2C_ACK;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR_DATA;
          end
        end
        // Bit 7 went out on entry; falls 1..7 present bits 6..0, fall 8 releases.
        ST_RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == I2C_LAST_BIT) begin
            sda_oe_d  = 1'b0;
            state_d   = ST_RD_ACK;
            bit_cnt_d = 3'd0;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) state_d = ST_WAIT_STOP;
            else                   tx_req_d = 1'b1;
          end else if (scl_fall) begin
            state_d   = ST_RD_DATA;
            shift_d   = bus.tx_data_i;
            sda_oe_d  = ~bus.tx_data_i[7];
            bit_cnt_d = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe_o    = sda_oe_q;
  assign bus.start_o     = start_p;
  assign bus.stop_o      = stop_p;
  assign bus.addressed_o = addressed_q;
  assign bus.rw_o        = rw_q;
  assign bus.rx_data_o   = rx_data_q;
  assign bus.rx_valid_o  = rx_valid_q;
  assign bus.tx_req_o    = tx_req_q;
  assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_frontend.sv
// Transaction-level bench for i2c_slave_frontend: a bit-banged I2C master,
// a register-side responder, and a model of what each transfer must yield.
module tb_i2c_slave_frontend;

  localparam int Q = 5;  // clk_i cycles per quarter SCL period

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  i2c_slave_frontend_if bus();

  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [6:0] own = 7'h52;

  assign bus.scl_i           = scl_m;
  assign bus.sda_i           = sda_m & ~bus.sda_oe_o;  // open-drain wired-AND
  assign bus.slave_address_i = own;

  i2c_slave_frontend #(.SYNC_STAGES(2)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_rx[$];   // write bytes the DUT must still strobe out
  logic [7:0] rd_q[$];     // bytes handed to the DUT, not yet read back
  logic [7:0] tx_src[$];   // preset read bytes (random when empty)
  logic [7:0] wr_src[$];   // preset write bytes (random when empty)
  logic [7:0] rd_log[$];   // bytes the master actually read
  bit addr_ok = 1'b0;
  bit exp_rw  = 1'b0;
  int n_start = 0, n_stop = 0, n_rx = 0, n_txreq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Compare process + register-side responder.
  initial begin
    logic [7:0] b;
    bus.tx_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        if (bus.start_o) n_start++;
        if (bus.stop_o)  n_stop++;
        if (bus.rx_valid_o) begin
          n_rx++;
          if (exp_rx.size() == 0) fail_now("rx_valid_unexpected");
          else check("rx_data", bus.rx_data_o, exp_rx.pop_front());
        end
        if (bus.tx_req_o) begin
          n_txreq++;
          b = (tx_src.size() != 0) ? tx_src.pop_front() : 8'($urandom_range(0, 255));
          bus.tx_data_i = b;
          rd_q.push_back(b);
        end
        if (bus.addressed_o || bus.sda_oe_o) begin
          checks++;
          if (!addr_ok) begin
            failures++;
            $display("FAIL drive_unaddressed addressed=%0b sda_oe=%0b required=0",
                     bus.addressed_o, bus.sda_oe_o);
          end
        end
        if (bus.addressed_o) check("rw_o", bus.rw_o, exp_rw);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_bit(input bit b, output bit line);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    line = bus.sda_i;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    bit l;
    for (int i = 7; i >= 0; i--) send_bit(b[i], l);
    send_bit(1'b1, ack);
  endtask

  // One addressed transfer, START included, STOP left to the caller.
  task automatic xfer(input logic [6:0] addr, input bit rw, input int n);
    bit line, ok;
    logic [7:0] d, got;
    int tx0;
    start_cond();
    ok = (addr == own) && (own != 7'd0);
    addr_ok = ok;
    exp_rw = rw;
    tx0 = n_txreq;
    send_byte({addr, rw}, line);
    check("addr_ack", line, ok ? 0 : 1);
    check("addressed", bus.addressed_o, ok);
    if (ok && !rw) begin
      for (int k = 0; k < n; k++) begin
        d = (wr_src.size() != 0) ? wr_src.pop_front() : 8'($urandom_range(0, 255));
        exp_rx.push_back(d);
        send_byte(d, line);
        check("wr_ack", line, 0);
      end
    end
    if (ok && rw) begin
      for (int k = 0; k < n; k++) begin
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
          send_bit(1'b1, line);
          got = {got[6:0], line};
        end
        rd_log.push_back(got);
        if (rd_q.size() == 0) fail_now("rd_without_tx_req");
        else check("rd_byte", got, rd_q.pop_front());
        send_bit(k == n - 1, line);
        if (k == n - 1) check("nack_released", line, 1);
      end
    end
    check("tx_req_count", n_txreq - tx0, (ok && rw) ? n : 0);
  endtask

  initial begin
    int s0, p0, r0;
    logic [6:0] a;
    bit rw;
    int n;

    // Reset state
    wait_clk(3);
    check("rst_sda_oe", bus.sda_oe_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_addressed", bus.addressed_o, 0);
    check("rst_rx_data", bus.rx_data_o, 8'h00);
    check("rst_strobes", {bus.rx_valid_o, bus.tx_req_o, bus.start_o, bus.stop_o}, 0);
    rst_n_i = 1'b1;
    wait_clk(5);

    // Reset in the middle of the address byte
    r0 = n_rx;
    start_cond();
    begin
      bit l;
      for (int i = 0; i < 4; i++) send_bit(i[0] == 1'b0, l);
    end
    rst_n_i = 1'b0;
    wait_clk(1);
    check("midrst_sda_oe", bus.sda_oe_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_strobes", {bus.rx_valid_o, bus.tx_req_o, bus.addressed_o}, 0);
    scl_m = 1'b1;
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(5);
    rst_n_i = 1'b1;
    wait_clk(5);
    check("midrst_no_rx", n_rx - r0, 0);

    // Write 0xA4, 0x3C to 0x52
    own = 7'h52;
    wr_src = '{8'hA4, 8'h3C};
    r0 = n_rx; p0 = n_stop;
    xfer(7'h52, 1'b0, 2);
    stop_cond();
    wait_clk(4);
    check("wr_rx_count", n_rx - r0, 2);
    check("wr_last_byte", bus.rx_data_o, 8'h3C);
    check("wr_stop_pulse", n_stop - p0, 1);
    check("wr_busy_after", bus.busy_o, 0);
    check("wr_addressed_after", bus.addressed_o, 0);

    // Foreign address
    xfer(7'h57, 1'b0, 1);
    check("foreign_waitstop_busy", bus.busy_o, 1);
    stop_cond();
    wait_clk(4);
    check("foreign_busy_after", bus.busy_o, 0);

    // Read 0x81, 0x7E, ACK then NACK
    tx_src = '{8'h81, 8'h7E};
    rd_log.delete();
    xfer(7'h52, 1'b1, 2);
    stop_cond();
    wait_clk(4);
    check("rd_byte0_literal", rd_log[0], 8'h81);
    check("rd_byte1_literal", rd_log[1], 8'h7E);
    check("rd_released", bus.sda_oe_o, 0);

    // Repeated START: write 1 byte, then read
    s0 = n_start; r0 = n_rx; p0 = n_stop;
    xfer(7'h52, 1'b0, 1);
    xfer(7'h52, 1'b1, 1);
    stop_cond();
    wait_clk(4);
    check("rs_start_count", n_start - s0, 2);
    check("rs_rx_count", n_rx - r0, 1);
    check("rs_stop_count", n_stop - p0, 1);

    // Unset own address, master sends address 0
    own = 7'd0;
    xfer(7'd0, 1'b0, 1);
    stop_cond();
    wait_clk(4);
    check("unset_busy_after", bus.busy_o, 0);

    // Randomized transfers, some chained with repeated START
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 7))
        0:       own = 7'd0;
        1, 2:    own = 7'($urandom_range(1, 127));
        default: own = 7'h52;
      endcase
      a  = ($urandom_range(0, 1) == 1) ? own : 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      r0 = n_rx;
      xfer(a, rw, n);
      wait_clk(2);
      check("rnd_rx_count", n_rx - r0, (addr_ok && !exp_rw) ? n : 0);
      check("rnd_rx_drained", exp_rx.size(), 0);
      check("rnd_rd_drained", rd_q.size(), 0);
      if ($urandom_range(0, 3) != 0) begin
        p0 = n_stop;
        stop_cond();
        wait_clk(4);
        check("rnd_stop", n_stop - p0, 1);
        check("rnd_idle", {bus.busy_o, bus.addressed_o, bus.sda_oe_o}, 0);
      end
    end
    stop_cond();
    wait_clk(4);
    check("final_idle", bus.busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
